// File: rtl/io_crc16d16_chk_pkg.sv
// Shared CRC16 (x^16+x^12+x^5+1) definitions for the IO link generator and checker.
// Holds the CRC constants, the checker FSM encoding and the 16-bit-parallel next-CRC function.
package io_crc16d16_chk_pkg;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } chk_state_e;

  // Folds one 16-bit word into the CRC, MSB of the word first.
  function automatic logic [15:0] crc16_d16_next(input logic [15:0] crc, input logic [15:0] din);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ din[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC16_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/io_crc16d16_next.sv
// Combinational next-CRC wrapper; instantiated by both the link generator and the checker
// so the two sides always use one equation set.
module io_crc16d16_next
  import io_crc16d16_chk_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [15:0] din_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_d16_next(crc_i, din_i);

endmodule

// File: rtl/io_crc16d16_chk.sv
// Receive-side CRC16 frame checker: one pass/fail verdict per frame of N payload words + CRC word.
// Optional build macro IO_CRC_ERR_CNT_EN adds a saturating error counter (err_cnt) with clear (err_cnt_clr).
//
//  state | meaning
//  IDLE  | waiting for a start-of-frame word
//  RECV  | accumulating payload CRC, counting words
//  DROP  | payload exceeded MAX_WORDS; discarding until eop
module io_crc16d16_chk
  import io_crc16d16_chk_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int LEN_W     = 9
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic [15:0]      rx_din,
  input  logic             rx_vld,
  input  logic             rx_sop,
  input  logic             rx_eop,
  output logic             chk_done,
  output logic             chk_pass,
  output logic             chk_err_crc,
  output logic             chk_err_len,
  output logic [LEN_W-1:0] frm_len
`ifdef IO_CRC_ERR_CNT_EN
  ,
  input  logic             err_cnt_clr,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_WORDS + 1);

  chk_state_e       state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             errc_q, errc_d;
  logic             errl_q, errl_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [15:0]      crc_base;
  logic [15:0]      crc_nxt;
  logic [LEN_W-1:0] cnt_inc;

  // A new frame always starts from the init value, even when it aborts a running one.
  assign crc_base = (state_q == ST_IDLE || rx_sop) ? CRC16_INIT : crc_q;
  assign cnt_inc  = cnt_q + LEN_ONE;

  io_crc16d16_next u_next (
    .crc_i (crc_base),
    .din_i (rx_din),
    .crc_o (crc_nxt)
  );

  // State and verdict registers.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= ST_IDLE;
      crc_q   <= CRC16_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      errc_q  <= 1'b0;
      errl_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      errc_q  <= errc_d;
      errl_q  <= errl_d;
      len_q   <= len_d;
    end
  end

  // Next-state, CRC accumulation and verdict decode; only valid words move anything.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    errc_d  = errc_q;
    errl_d  = errl_q;
    len_d   = len_q;
    if (rx_vld) begin
      if (rx_sop && state_q != ST_IDLE) begin
        // Abort the running frame; a sop&eop word here yields only the abort verdict.
        done_d  = 1'b1;
        pass_d  = 1'b0;
        errc_d  = 1'b0;
        errl_d  = 1'b1;
        len_d   = cnt_q;
        state_d = ST_IDLE;
        crc_d   = CRC16_INIT;
        cnt_d   = '0;
        if (!rx_eop) begin
          state_d = ST_RECV;
          crc_d   = crc_nxt;
          cnt_d   = LEN_ONE;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_sop) begin
              if (rx_eop) begin
                done_d = 1'b1;
                pass_d = 1'b0;
                errc_d = 1'b0;
                errl_d = 1'b1;
                len_d  = '0;
              end else begin
                state_d = ST_RECV;
                crc_d   = crc_nxt;
                cnt_d   = LEN_ONE;
              end
            end
          end
          ST_RECV: begin
            if (rx_eop) begin
              done_d  = 1'b1;
              pass_d  = (rx_din == crc_q);
              errc_d  = (rx_din != crc_q);
              errl_d  = 1'b0;
              len_d   = cnt_q;
              state_d = ST_IDLE;
              crc_d   = CRC16_INIT;
              cnt_d   = '0;
            end else begin
              crc_d = crc_nxt;
              cnt_d = cnt_inc;
              if (cnt_inc == LEN_SAT) state_d = ST_DROP;
            end
          end
          ST_DROP: begin
            if (rx_eop) begin
              done_d  = 1'b1;
              pass_d  = 1'b0;
              errc_d  = 1'b0;
              errl_d  = 1'b1;
              len_d   = LEN_SAT;
              state_d = ST_IDLE;
              crc_d   = CRC16_INIT;
              cnt_d   = '0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign chk_done    = done_q;
  assign chk_pass    = pass_q;
  assign chk_err_crc = errc_q;
  assign chk_err_len = errl_q;
  assign frm_len     = len_q;

`ifdef IO_CRC_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of failed verdicts; clear beats a same-cycle increment.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n)                                       err_cnt_q <= '0;
    else if (err_cnt_clr)                                 err_cnt_q <= '0;
    else if (done_q && !pass_q && err_cnt_q != 16'hFFFF)  err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
